// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch FSM states, queue-entry layout and instruction size
package fetch_pkg;
  localparam int INSTR_BYTES = 4;
  typedef enum logic [1:0] {IDLE, REQUEST, DISCARD, HALT} fetch_state_t;
  // Entry layout at the default 32/32 geometry; the queue stores the same field order packed
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        misaligned;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction queue with push, pop, flush and occupancy count
// ports: i_clk, i_rst (async high), i_push/i_data tail write, i_pop head retire,
//        i_flush empties the queue and wins over push/pop, o_data head entry, o_count occupancy
module fetch_queue #(
  parameter int W     = 65,
  parameter int DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [W-1:0]           i_data,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [PW:0]   r_cnt;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + PW'(i_push);
      r_rd  <= r_rd + PW'(i_pop);
      r_cnt <= r_cnt + (PW+1)'(i_push) - (PW+1)'(i_pop);
    end
  always_ff @(posedge i_clk)
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM feeding a decode queue, with redirect/flush handling
// ports: clk_i, rst_i (async high); mem_* request/response handshake to instruction memory;
//        redirect_i/redirect_pc_i flush and retarget; inst_* queue head to decode, decode_ready_i pops
// FETCH_MISALIGN_TRAP_EN: when defined, a misaligned PC queues a fault entry and halts until redirect;
//        otherwise redirect targets are forced word aligned and inst_misaligned_o is 0
module fetch_unit import fetch_pkg::*; #(
  parameter int                  ADDRES_BIT     = 32,
  parameter logic [ADDRES_BIT-1:0] INITIAL_ADDRES = 32'h8000_0000,
  parameter int                  DATA_BIT       = 32,
  parameter int                  QUEUE_DEPTH    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [ADDRES_BIT-1:0] mem_address_o,
  output logic                  mem_get_instruction_o,
  input  logic [DATA_BIT-1:0]   mem_instruction_i,
  input  logic                  mem_instruction_completed_i,
  input  logic                  redirect_i,
  input  logic [ADDRES_BIT-1:0] redirect_pc_i,
  output logic                  inst_valid_o,
  output logic [DATA_BIT-1:0]   inst_o,
  output logic [ADDRES_BIT-1:0] inst_pc_o,
  input  logic                  decode_ready_i,
  output logic                  inst_misaligned_o
);
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam int MB = 1;
`else
  localparam int MB = 0;
`endif
  localparam int EW = DATA_BIT + ADDRES_BIT + MB;
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  fetch_state_t          r_state, w_next;
  logic [ADDRES_BIT-1:0] r_pc, r_addr, w_pc_next, w_redir_pc;
  logic                  w_push, w_pop, w_free, w_aligned;
  logic [EW-1:0]         w_push_data, w_head;
  logic [CW-1:0]         w_count;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_redir_pc        = redirect_pc_i;
  assign w_aligned         = r_pc[1:0] == 2'b00;
  // The only push made from IDLE is the misalignment fault entry
  assign w_push_data       = (r_state == IDLE) ? {{DATA_BIT{1'b0}}, r_pc, 1'b1} : {mem_instruction_i, r_pc, 1'b0};
  assign inst_misaligned_o = inst_valid_o & w_head[0];
`else
  assign w_redir_pc        = redirect_pc_i & ~ADDRES_BIT'(3);
  assign w_aligned         = 1'b1;
  assign w_push_data       = {mem_instruction_i, r_pc};
  assign inst_misaligned_o = 1'b0;
`endif
  assign w_free                = w_count < CW'(QUEUE_DEPTH);
  assign inst_valid_o          = w_count != '0;
  // A redirect flushes the queue, so any transfer in that cycle is cancelled
  assign w_pop                 = inst_valid_o & decode_ready_i & ~redirect_i;
  assign inst_o                = inst_valid_o ? w_head[MB+ADDRES_BIT +: DATA_BIT] : '0;
  assign inst_pc_o             = inst_valid_o ? w_head[MB +: ADDRES_BIT] : '0;
  assign mem_get_instruction_o = (r_state == REQUEST) | (r_state == DISCARD);
  assign mem_address_o         = r_addr;
  always_comb begin
    w_next    = r_state;
    w_pc_next = redirect_i ? w_redir_pc : r_pc;
    w_push    = 1'b0;
    case (r_state)
      IDLE:
        if (!redirect_i && w_free) begin
          w_next = w_aligned ? REQUEST : HALT;
          w_push = !w_aligned;
        end
      REQUEST:
        if (redirect_i) w_next = mem_instruction_completed_i ? IDLE : DISCARD;
        else if (mem_instruction_completed_i) begin
          w_next    = IDLE;
          w_push    = 1'b1;
          w_pc_next = r_pc + ADDRES_BIT'(INSTR_BYTES);
        end
      DISCARD: w_next = mem_instruction_completed_i ? IDLE : DISCARD;
      default: w_next = redirect_i ? IDLE : HALT;
    endcase
  end
  // r_addr holds the request address so a redirect during DISCARD cannot disturb it
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state <= IDLE;
      r_pc    <= INITIAL_ADDRES;
      r_addr  <= INITIAL_ADDRES;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      if (r_state == IDLE && w_next == REQUEST) r_addr <= r_pc;
    end
  fetch_queue #(.W(EW), .DEPTH(QUEUE_DEPTH)) u_queue (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .i_data  (w_push_data),
    .o_data  (w_head),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a stream-level reference model
module tb_fetch_unit;
  localparam logic [31:0] INIT  = 32'h8000_0000;
  localparam int          DEPTH = 2;
  logic        clk = 1'b0, rst_i = 1'b1;
  logic [31:0] mem_address_o, inst_o, inst_pc_o;
  logic [31:0] mem_instruction_i = '0, redirect_pc_i = '0;
  logic        mem_get_instruction_o, inst_valid_o, inst_misaligned_o;
  logic        mem_instruction_completed_i = 1'b0, redirect_i = 1'b0, decode_ready_i = 1'b0;
  int          checks = 0, failures = 0;
  int          lat = 0, mwait = 0, mcount = 0, nreq = 0;
  logic        model_on = 1'b1, stale = 1'b0, pget = 1'b0, pcmp = 1'b0;
  logic [31:0] exp_pc = INIT, exp_req = INIT, paddr = '0;
  logic [31:0] req_log[$], pop_log[$];

  fetch_unit #(.ADDRES_BIT(32), .INITIAL_ADDRES(INIT), .DATA_BIT(32), .QUEUE_DEPTH(DEPTH)) dut (
    .clk_i                       (clk),
    .rst_i                       (rst_i),
    .mem_address_o               (mem_address_o),
    .mem_get_instruction_o       (mem_get_instruction_o),
    .mem_instruction_i           (mem_instruction_i),
    .mem_instruction_completed_i (mem_instruction_completed_i),
    .redirect_i                  (redirect_i),
    .redirect_pc_i               (redirect_pc_i),
    .inst_valid_o                (inst_valid_o),
    .inst_o                      (inst_o),
    .inst_pc_o                   (inst_pc_o),
    .decode_ready_i              (decode_ready_i),
    .inst_misaligned_o           (inst_misaligned_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'hC3C3_0F0F;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
`ifdef FETCH_MISALIGN_TRAP_EN
    return a;
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

  task automatic model_reset();
    mcount = 0; mwait = 0; nreq = 0; stale = 1'b0; pget = 1'b0; pcmp = 1'b0;
    exp_pc = INIT; exp_req = INIT;
    req_log.delete(); pop_log.delete();
  endtask

  task automatic do_reset();
    rst_i = 1'b1; mem_instruction_completed_i = 1'b0; redirect_i = 1'b0; decode_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    model_reset();
  endtask

  // One clock: sample outputs, answer memory, apply decode/redirect inputs, update the model
  task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc);
    logic get, v, mis, pop, cmp;
    logic [31:0] addr, ipc, ins;
    @(negedge clk);
    get = mem_get_instruction_o; addr = mem_address_o; v = inst_valid_o;
    ipc = inst_pc_o; ins = inst_o; mis = inst_misaligned_o;
    if (get && !pget) begin
      nreq++;
      req_log.push_back(addr);
    end
    if (model_on) begin
      checks++;
      if (v !== (mcount != 0)) begin
        failures++; $display("FAIL valid: got %b want %b at %0t", v, mcount != 0, $time);
      end
      if (get && !pget) begin
        checks++;
        if (addr !== exp_req || mcount >= DEPTH) begin
          failures++; $display("FAIL req_start: addr %h want %h, queued %0d", addr, exp_req, mcount);
        end
        exp_req = addr + 32'd4;
      end
      if (get && pget) begin
        checks++;
        if (addr !== paddr) begin
          failures++; $display("FAIL addr_stable: got %h want %h", addr, paddr);
        end
      end
      if (pcmp) begin
        checks++;
        if (get !== 1'b0) begin
          failures++; $display("FAIL strobe_gap: got %b want 0", get);
        end
      end
`ifndef FETCH_MISALIGN_TRAP_EN
      checks++;
      if (mis !== 1'b0) begin
        failures++; $display("FAIL misaligned_tied: got %b want 0", mis);
      end
`endif
    end
    cmp = 1'b0;
    if (get) begin
      if (mwait >= lat) begin
        cmp = 1'b1; mwait = 0;
      end else mwait++;
    end
    mem_instruction_completed_i = cmp;
    mem_instruction_i = cmp ? mem_word(addr) : $urandom();
    decode_ready_i = rdy; redirect_i = rd; redirect_pc_i = rpc;
    pop = v && rdy && !rd;
    if (pop) begin
      pop_log.push_back(ipc);
      if (model_on) begin
        checks++;
        if (ipc !== exp_pc || ins !== mem_word(ipc) || mis !== 1'b0) begin
          failures++; $display("FAIL pop: pc %h inst %h mis %b want pc %h inst %h", ipc, ins, mis, exp_pc, mem_word(exp_pc));
        end
      end
      exp_pc = ipc + 32'd4;
      mcount--;
    end
    if (cmp && !rd && !stale) mcount++;
    if (cmp) stale = 1'b0;
    if (rd) begin
      mcount = 0; exp_pc = align(rpc); exp_req = align(rpc);
      if (get && !cmp) stale = 1'b1;
    end
    pget = get; paddr = addr; pcmp = cmp;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_get_instruction_o, inst_valid_o, inst_misaligned_o} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got %b want 000", {mem_get_instruction_o, inst_valid_o, inst_misaligned_o});
    end
    checks++;
    if (mem_address_o !== INIT) begin
      failures++; $display("FAIL reset_addr: got %h want %h", mem_address_o, INIT);
    end
    checks++;
    if (inst_o !== '0 || inst_pc_o !== '0) begin
      failures++; $display("FAIL reset_head: inst %h pc %h want 0", inst_o, inst_pc_o);
    end
  endtask

  task automatic test_stream();
    do_reset(); lat = 0;
    repeat (12) step(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_log.size() <= i || req_log[i] !== INIT + 32'(4 * i)) begin
        failures++; $display("FAIL stream_req%0d: got %h want %h", i, req_log.size() > i ? req_log[i] : 32'hx, INIT + 32'(4 * i));
      end
      checks++;
      if (pop_log.size() <= i || pop_log[i] !== INIT + 32'(4 * i)) begin
        failures++; $display("FAIL stream_pop%0d: got %h want %h", i, pop_log.size() > i ? pop_log[i] : 32'hx, INIT + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(); lat = 20;
    repeat (80) step(1'b0, 1'b0, '0);
    #1;
    checks++;
    if (nreq != 2 || inst_valid_o !== 1'b1) begin
      failures++; $display("FAIL full_queue: requests %0d valid %b want 2 1", nreq, inst_valid_o);
    end
    step(1'b1, 1'b0, '0);
    repeat (40) step(1'b0, 1'b0, '0);
    checks++;
    if (nreq != 3) begin
      failures++; $display("FAIL refill_after_pop: requests %0d want 3", nreq);
    end
  endtask

  task automatic test_discard();
    do_reset(); lat = 5;
    for (int i = 0; i < 100 && nreq < 3; i++) step(1'b1, 1'b0, '0);
    #1;
    checks++;
    if (mem_get_instruction_o !== 1'b1 || mem_address_o !== INIT + 32'd8) begin
      failures++; $display("FAIL pending_req: get %b addr %h want 1 %h", mem_get_instruction_o, mem_address_o, INIT + 32'd8);
    end
    step(1'b1, 1'b1, 32'h8000_0100);
    #1;
    checks++;
    if (mem_get_instruction_o !== 1'b1 || mem_address_o !== INIT + 32'd8) begin
      failures++; $display("FAIL discard_hold: get %b addr %h want 1 %h", mem_get_instruction_o, mem_address_o, INIT + 32'd8);
    end
    for (int i = 0; i < 50 && nreq < 4; i++) step(1'b1, 1'b0, '0);
    checks++;
    if (nreq < 4 || req_log[3] !== 32'h8000_0100) begin
      failures++; $display("FAIL discard_next: requests %0d addr %h want 4 80000100", nreq, nreq >= 4 ? req_log[3] : 32'hx);
    end
    repeat (20) step(1'b1, 1'b0, '0);
  endtask

  task automatic test_redirect_pop();
    do_reset(); lat = 0;
    for (int i = 0; i < 20 && mcount < 2; i++) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    #1;
    checks++;
    if (inst_valid_o !== 1'b1 || inst_pc_o !== INIT + 32'd4) begin
      failures++; $display("FAIL head_before_redirect: valid %b pc %h want 1 %h", inst_valid_o, inst_pc_o, INIT + 32'd4);
    end
    step(1'b1, 1'b1, 32'h8000_0200);
    #1;
    checks++;
    if (inst_valid_o !== 1'b0) begin
      failures++; $display("FAIL flush_valid: got %b want 0", inst_valid_o);
    end
    pop_log.delete();
    repeat (30) step(1'b1, 1'b0, '0);
    checks++;
    if (pop_log.size() == 0 || pop_log[0] !== 32'h8000_0200) begin
      failures++; $display("FAIL new_stream: first pc %h want 80000200", pop_log.size() > 0 ? pop_log[0] : 32'hx);
    end
  endtask

`ifdef FETCH_MISALIGN_TRAP_EN
  task automatic test_misalign();
    int n0;
    do_reset(); lat = 0; model_on = 1'b0;
    step(1'b0, 1'b1, 32'h8000_0102);
    repeat (3) step(1'b0, 1'b0, '0);
    n0 = nreq;
    repeat (15) step(1'b0, 1'b0, '0);
    #1;
    checks++;
    if (nreq != n0 || inst_valid_o !== 1'b1 || inst_misaligned_o !== 1'b1) begin
      failures++; $display("FAIL halt_entry: new reqs %0d valid %b mis %b want 0 1 1", nreq - n0, inst_valid_o, inst_misaligned_o);
    end
    checks++;
    if (inst_pc_o !== 32'h8000_0102 || inst_o !== '0) begin
      failures++; $display("FAIL halt_pc: pc %h inst %h want 80000102 0", inst_pc_o, inst_o);
    end
    step(1'b0, 1'b1, INIT);
    repeat (4) step(1'b0, 1'b0, '0);
    checks++;
    if (nreq != n0 + 1 || req_log[req_log.size()-1] !== INIT) begin
      failures++; $display("FAIL halt_exit: new reqs %0d addr %h want 1 %h", nreq - n0, req_log[req_log.size()-1], INIT);
    end
    model_on = 1'b1;
  endtask
`else
  task automatic test_misalign();
    do_reset(); lat = 0;
    step(1'b1, 1'b1, 32'h8000_0102);
    for (int i = 0; i < 10 && nreq < 2; i++) step(1'b1, 1'b0, '0);
    checks++;
    if (nreq < 2 || req_log[1] !== 32'h8000_0100) begin
      failures++; $display("FAIL align_mask: requests %0d addr %h want 2 80000100", nreq, nreq >= 2 ? req_log[1] : 32'hx);
    end
    repeat (10) step(1'b1, 1'b0, '0);
  endtask
`endif

  task automatic test_reset_mid();
    do_reset(); lat = 10;
    repeat (4) step(1'b1, 1'b0, '0);
    #1;
    checks++;
    if (mem_get_instruction_o !== 1'b1) begin
      failures++; $display("FAIL mid_request: get %b want 1", mem_get_instruction_o);
    end
    #1 rst_i = 1'b1;
    #1;
    checks++;
    if (mem_get_instruction_o !== 1'b0 || inst_valid_o !== 1'b0 || mem_address_o !== INIT) begin
      failures++; $display("FAIL async_reset: get %b valid %b addr %h want 0 0 %h", mem_get_instruction_o, inst_valid_o, mem_address_o, INIT);
    end
    mem_instruction_completed_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    model_reset(); lat = 0;
    repeat (6) step(1'b1, 1'b0, '0);
    checks++;
    if (req_log.size() < 2 || req_log[0] !== INIT || req_log[1] !== INIT + 32'd4) begin
      failures++; $display("FAIL refetch: %0d requests, first %h want %h", req_log.size(), req_log.size() > 0 ? req_log[0] : 32'hx, INIT);
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      lat = $urandom_range(0, 3);
      t = INIT + $urandom_range(0, 255);
`ifdef FETCH_MISALIGN_TRAP_EN
      t = t & ~32'd3;
`endif
      step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, t);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_discard();
    test_redirect_pop();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
